// File: rtl/decoder_n_pipe.sv
// N-to-2^N decoder (one-hot or thermometer) behind a valid/ready handshake,
// with a 2-entry result buffer and an internal round-robin index source.
module decoder_n_pipe #(
  parameter int WIDTH     = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_x,
  input  logic                  in_use_rr,
  input  logic                  in_mode,
  input  logic                  in_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2**WIDTH-1:0]   out_y,
  output logic [WIDTH-1:0]      out_idx,
  output logic [WIDTH-1:0]      rr_idx
);

  localparam int DEPTH = 2**WIDTH;

  typedef struct packed {
    logic [DEPTH-1:0] vec;
    logic [WIDTH-1:0] idx;
  } entry_t;

  entry_t           buf_q [2];
  logic [1:0]       count_q;
  logic             wptr_q;
  logic             rptr_q;
  logic [WIDTH-1:0] rr_q;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] sel;
  logic [DEPTH-1:0] vec;

  // Ready depends on occupancy only, so a full buffer never accepts even
  // when the consumer drains in the same cycle.
  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign sel       = in_use_rr ? rr_q : in_x;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    vec = '0;
    if (in_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (MSB_FIRST) vec[DEPTH-1-i] = in_mode ? (i <= int'(sel)) : (i == int'(sel));
        else           vec[i]         = in_mode ? (i <= int'(sel)) : (i == int'(sel));
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      rr_q    <= '0;
    end else begin
      if (push) begin
        wptr_q <= ~wptr_q;
        if (in_use_rr) rr_q <= rr_q + WIDTH'(1);
      end
      if (pop) rptr_q <= ~rptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: buffer storage is not reset; out_valid gates it, so stale data never escapes.
  always_ff @(posedge clk) begin
    if (push) buf_q[wptr_q] <= '{vec: vec, idx: sel};
  end

  assign out_y   = out_valid ? buf_q[rptr_q].vec : '0;
  assign out_idx = out_valid ? buf_q[rptr_q].idx : '0;
  assign rr_idx  = rr_q;

endmodule

// File: tb/tb_decoder_n_pipe.sv
// Randomized bench for decoder_n_pipe: a queue-based model of the buffer and
// arithmetic decode rules predict every output, for both bit orderings.
module tb_decoder_n_pipe;

  localparam int W = 3;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_x = '0;
  logic         in_use_rr = 1'b0;
  logic         in_mode = 1'b0;
  logic         in_en = 1'b1;
  logic         out_ready = 1'b1;

  logic         in_ready, out_valid;
  logic [D-1:0] out_y;
  logic [W-1:0] out_idx, rr_idx;

  logic         l_in_ready, l_out_valid;
  logic [D-1:0] l_out_y;
  logic [W-1:0] l_out_idx, l_rr_idx;

  int passed = 0;
  int total  = 0;

  logic [D-1:0] qy[$];
  logic [D-1:0] ql[$];
  int           qi[$];
  int           rr_m = 0;

  always #5 clk = ~clk;

  decoder_n_pipe #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .in_use_rr(in_use_rr), .in_mode(in_mode), .in_en(in_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_idx(out_idx), .rr_idx(rr_idx)
  );

  decoder_n_pipe #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready), .in_x(in_x),
    .in_use_rr(in_use_rr), .in_mode(in_mode), .in_en(in_en), .out_valid(l_out_valid),
    .out_ready(out_ready), .out_y(l_out_y), .out_idx(l_out_idx), .rr_idx(l_rr_idx)
  );

  // Expected vector from the decode rules: index s lands on bit D-1-s (MSB-first) or s.
  function automatic logic [D-1:0] exp_vec(int s, bit mode, bit en, bit msb);
    int v;
    if (!en) return '0;
    if (msb) v = mode ? ((D'(1) << D) - (1 << (D-1-s))) : (1 << (D-1-s));
    else     v = mode ? ((1 << (s+1)) - 1)               : (1 << s);
    return v[D-1:0];
  endfunction

  // One clock of stimulus; called and returns at a falling edge.
  task automatic drive(input bit r, input bit v, input int x, input bit use_rr,
                       input bit mode, input bit en, input bit ordy);
    bit p_push, p_pop;
    int s;
    rst = r; in_valid = v; in_x = W'(x); in_use_rr = use_rr;
    in_mode = mode; in_en = en; out_ready = ordy;
    p_push = !r && v && (qy.size() < 2);
    p_pop  = !r && ordy && (qy.size() > 0);
    s = use_rr ? rr_m : x;
    @(posedge clk);
    if (r) begin
      qy.delete(); ql.delete(); qi.delete(); rr_m = 0;
    end else begin
      if (p_pop) begin
        void'(qy.pop_front()); void'(ql.pop_front()); void'(qi.pop_front());
      end
      if (p_push) begin
        qy.push_back(exp_vec(s, mode, en, 1'b1));
        ql.push_back(exp_vec(s, mode, en, 1'b0));
        qi.push_back(s);
        if (use_rr) rr_m = (rr_m + 1) % D;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 1, 1);
  endtask

  task automatic test_reset;
    drive(1, 0, 0, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 0, 1, 1);
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (out_y !== 8'h00) $display("FAIL reset_out_y: got %h want 00", out_y); else passed++;
    total++; if (out_idx !== 3'd0) $display("FAIL reset_out_idx: got %0d want 0", out_idx); else passed++;
    total++; if (rr_idx !== 3'd0) $display("FAIL reset_rr_idx: got %0d want 0", rr_idx); else passed++;
  endtask

  task automatic test_onehot;
    for (int x = 0; x < D; x++) begin
      drive(0, 1, x, 0, 0, 1, 1);
      total++;
      if (out_valid !== 1'b1 || out_y !== qy[0] || out_y !== (8'h80 >> x) || int'(out_idx) != x)
        $display("FAIL onehot x=%0d: valid=%b y=%h idx=%0d want valid=1 y=%h idx=%0d",
                 x, out_valid, out_y, out_idx, qy[0], x);
      else passed++;
    end
    idle(1);
  endtask

  task automatic test_thermo;
    int xs[3] = '{0, 3, 7};
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, xs[k], 0, 1, 1, 1);
      total++;
      if (out_y !== qy[0] || l_out_y !== ql[0])
        $display("FAIL thermo x=%0d: y=%h y_lsb=%h want %h %h", xs[k], out_y, l_out_y, qy[0], ql[0]);
      else passed++;
    end
    idle(1);
  endtask

  task automatic test_disable;
    drive(0, 1, 5, 0, 0, 0, 1);
    total++;
    if (out_valid !== 1'b1 || out_y !== 8'h00 || out_idx !== 3'd5)
      $display("FAIL disable: valid=%b y=%h idx=%0d want 1 00 5", out_valid, out_y, out_idx);
    else passed++;
    idle(1);
  endtask

  task automatic test_round_robin;
    for (int k = 0; k < 9; k++) begin
      drive(0, 1, $urandom_range(D-1), 1, 1'($urandom), 1, 1);
      total++;
      if (int'(out_idx) != (k % D) || out_y !== qy[0])
        $display("FAIL rr_push k=%0d: idx=%0d y=%h want %0d %h", k, out_idx, out_y, k % D, qy[0]);
      else passed++;
    end
    total++; if (rr_idx !== 3'd1) $display("FAIL rr_after_nine: got %0d want 1", rr_idx); else passed++;
    drive(0, 1, 2, 0, 0, 1, 1);
    total++;
    if (rr_idx !== 3'd1 || out_idx !== 3'd2)
      $display("FAIL rr_unchanged: rr=%0d idx=%0d want 1 2", rr_idx, out_idx);
    else passed++;
    idle(1);
  endtask

  task automatic test_backpressure;
    int xs[3];
    int pops = 0;
    for (int k = 0; k < 3; k++) begin
      xs[k] = $urandom_range(D-1);
      drive(0, 1, xs[k], 0, 1'($urandom), 1, 0);
      total++;
      if (in_ready !== (qy.size() < 2) || out_y !== qy[0] || int'(out_idx) != xs[0])
        $display("FAIL stall k=%0d: ready=%b y=%h idx=%0d want %b %h %0d",
                 k, in_ready, out_y, out_idx, qy.size() < 2, qy[0], xs[0]);
      else passed++;
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (out_valid !== (qy.size() > 0) || (qy.size() > 0 && (out_y !== qy[0] || int'(out_idx) != qi[0])))
        $display("FAIL drain k=%0d: valid=%b y=%h idx=%0d want valid=%b", k, out_valid, out_y, out_idx, qy.size() > 0);
      else passed++;
      if (out_valid === 1'b1) pops++;
      drive(0, 0, 0, 0, 0, 1, 1);
    end
    total++;
    if (pops != 2) $display("FAIL drain_count: got %0d want 2", pops); else passed++;
  endtask

  task automatic test_random;
    logic [D-1:0] ey, el;
    int ei;
    for (int c = 0; c < 300; c++) begin
      drive(0, 1'($urandom_range(3) != 0), $urandom_range(D-1), 1'($urandom), 1'($urandom),
            1'($urandom_range(7) != 0), 1'($urandom_range(3) != 0));
      ey = (qy.size() > 0) ? qy[0] : '0;
      el = (ql.size() > 0) ? ql[0] : '0;
      ei = (qi.size() > 0) ? qi[0] : 0;
      total++;
      if (out_valid !== (qy.size() > 0) || in_ready !== (qy.size() < 2) || out_y !== ey ||
          l_out_y !== el || int'(out_idx) != ei || int'(rr_idx) != rr_m)
        $display("FAIL random c=%0d: v=%b r=%b y=%h yl=%h idx=%0d rr=%0d want %b %b %h %h %0d %0d",
                 c, out_valid, in_ready, out_y, l_out_y, out_idx, rr_idx,
                 qy.size() > 0, qy.size() < 2, ey, el, ei, rr_m);
      else passed++;
    end
    idle(2);
  endtask

  task automatic test_reset_mid;
    drive(0, 1, 3, 1, 0, 1, 0);
    drive(0, 1, 6, 1, 1, 1, 0);
    total++; if (in_ready !== 1'b0) $display("FAIL mid_full: ready=%b want 0", in_ready); else passed++;
    drive(1, 0, 0, 0, 0, 1, 0);
    total++;
    if (out_valid !== 1'b0 || out_y !== 8'h00 || rr_idx !== 3'd0 || in_ready !== 1'b1)
      $display("FAIL mid_reset: valid=%b y=%h rr=%0d ready=%b want 0 00 0 1",
               out_valid, out_y, rr_idx, in_ready);
    else passed++;
    idle(1);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_onehot();
    test_thermo();
    test_disable();
    test_round_robin();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
